// File: rtl/gpio_pkg.sv
// gpio_pkg: shared definitions for the GPIO controller.
//   - Register indices decoded on the 3-bit bus address (REG_OUT..REG_CLR).
//   - Default input synchroniser depth.
package gpio_pkg;

  localparam logic [2:0] REG_OUT   = 3'd0;  // output data, RW
  localparam logic [2:0] REG_DIR   = 3'd1;  // direction, 1 = output, RW
  localparam logic [2:0] REG_IN    = 3'd2;  // synchronised pin value, RO
  localparam logic [2:0] REG_IEN   = 3'd3;  // interrupt enable, RW
  localparam logic [2:0] REG_IEDGE = 3'd4;  // 1 = rising, 0 = falling, RW
  localparam logic [2:0] REG_PEND  = 3'd5;  // pending, read / write-1-to-clear
  localparam logic [2:0] REG_SET   = 3'd6;  // OUT |= wdata, WO
  localparam logic [2:0] REG_CLR   = 3'd7;  // OUT &= ~wdata, WO

  localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/gpio_sync.sv
// gpio_sync: input conditioning for the GPIO pads.
//   Asynchronous pads pass through a SYNC_STAGES-deep flop chain, then an
//   optional per-pin debounce filter (compiled in with GPIO_DEBOUNCE_EN),
//   then a previous-value flop used for edge detection.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   pin_raw   - asynchronous pad inputs
//   pin_val   - synchronised (and filtered) pin value
//   rise/fall - one-cycle edge indications of pin_val
module gpio_sync
  import gpio_pkg::*;
#(
  parameter int DW          = 16,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DB_CYCLES   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] pin_raw,
  output logic [DW-1:0] pin_val,
  output logic [DW-1:0] rise,
  output logic [DW-1:0] fall
);

  // Stage 0 is the metastability-catching flop; the last stage is the
  // clean synchronised value.
  logic [SYNC_STAGES-1:0][DW-1:0] sync_reg;
  logic [DW-1:0]                  sync_val;
  logic [DW-1:0]                  filt_val;
  logic [DW-1:0]                  prev_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], pin_raw};
    end
  end

  assign sync_val = sync_reg[SYNC_STAGES-1];

  genvar gi;

`ifdef GPIO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DB_CYCLES + 1);

  // The filtered bit only follows the synchronised bit once the two have
  // disagreed for DB_CYCLES consecutive cycles; any bounce back restarts
  // the count.
  for (gi = 0; gi < DW; gi++) begin : g_debounce
    logic [CNT_W-1:0] cnt_reg;
    logic             filt_bit_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_reg      <= '0;
        filt_bit_reg <= 1'b0;
      end else if (sync_val[gi] == filt_bit_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_W'(DB_CYCLES - 1)) begin
        cnt_reg      <= '0;
        filt_bit_reg <= sync_val[gi];
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end

    assign filt_val[gi] = filt_bit_reg;
  end
`else
  // Debounce compiled out: the filtered value is the synchronised value.
  // db_unused keeps DB_CYCLES referenced in this build.
  logic [31:0] db_unused;
  assign db_unused = 32'(DB_CYCLES);
  assign filt_val  = sync_val;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_reg <= '0;
    end else begin
      prev_reg <= filt_val;
    end
  end

  for (gi = 0; gi < DW; gi++) begin : g_edge
    assign rise[gi] = filt_val[gi] & ~prev_reg[gi];
    assign fall[gi] = ~filt_val[gi] & prev_reg[gi];
  end

  assign pin_val = filt_val;

endmodule

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: bus-mapped GPIO controller.
//   Per-pin direction, synchronised inputs, atomic set/clear of outputs and
//   per-pin edge interrupts aggregated onto a single irq line.
//   Optional input debounce is compiled in with the GPIO_DEBOUNCE_EN macro.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   sel, we, addr, wdata - register access (one-cycle strobe, 1 = write)
//   rdata               - registered read data, valid the cycle after a read
//   gpio_in             - asynchronous pad inputs
//   gpio_out, gpio_oe   - output data and output enable (= DIR)
//   irq                 - OR of enabled pending interrupts
module gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int DW          = 16,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DB_CYCLES   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sel,
  input  logic          we,
  input  logic [2:0]    addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  input  logic [DW-1:0] gpio_in,
  output logic [DW-1:0] gpio_out,
  output logic [DW-1:0] gpio_oe,
  output logic          irq
);

  logic [DW-1:0] out_reg,   out_next;
  logic [DW-1:0] dir_reg,   dir_next;
  logic [DW-1:0] ien_reg,   ien_next;
  logic [DW-1:0] iedge_reg, iedge_next;
  logic [DW-1:0] pend_reg,  pend_next;
  logic [DW-1:0] rdata_reg, rdata_next;
  logic          irq_reg,   irq_next;

  logic          wr_en;
  logic          rd_en;
  logic [DW-1:0] w1c_mask;
  logic [DW-1:0] pin_val;
  logic [DW-1:0] pin_rise;
  logic [DW-1:0] pin_fall;
  logic [DW-1:0] pin_event;

  gpio_sync #(
    .DW          (DW),
    .SYNC_STAGES (SYNC_STAGES),
    .DB_CYCLES   (DB_CYCLES)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .pin_raw (gpio_in),
    .pin_val (pin_val),
    .rise    (pin_rise),
    .fall    (pin_fall)
  );

  assign wr_en = sel & we;
  assign rd_en = sel & ~we;

  // Output pins never raise interrupts, whatever the edge setting.
  genvar gi;
  for (gi = 0; gi < DW; gi++) begin : g_event
    assign pin_event[gi] = ~dir_reg[gi] &
                           (iedge_reg[gi] ? pin_rise[gi] : pin_fall[gi]);
  end

  assign w1c_mask = (wr_en && addr == REG_PEND) ? wdata : '0;

  always_comb begin
    out_next   = out_reg;
    dir_next   = dir_reg;
    ien_next   = ien_reg;
    iedge_next = iedge_reg;
    if (wr_en) begin
      case (addr)
        REG_OUT:   out_next   = wdata;
        REG_DIR:   dir_next   = wdata;
        REG_IEN:   ien_next   = wdata;
        REG_IEDGE: iedge_next = wdata;
        REG_SET:   out_next   = out_reg | wdata;
        REG_CLR:   out_next   = out_reg & ~wdata;
        default:   ;
      endcase
    end
    // OR-ing the event in last lets a fresh edge survive a same-cycle clear.
    pend_next = (pend_reg & ~w1c_mask) | pin_event;
    irq_next  = |(pend_next & ien_next);
  end

  always_comb begin
    rdata_next = rdata_reg;
    if (rd_en) begin
      case (addr)
        REG_OUT:   rdata_next = out_reg;
        REG_DIR:   rdata_next = dir_reg;
        REG_IN:    rdata_next = pin_val;
        REG_IEN:   rdata_next = ien_reg;
        REG_IEDGE: rdata_next = iedge_reg;
        REG_PEND:  rdata_next = pend_reg;
        default:   rdata_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_reg   <= '0;
      dir_reg   <= '0;
      ien_reg   <= '0;
      iedge_reg <= '0;
      pend_reg  <= '0;
      rdata_reg <= '0;
      irq_reg   <= 1'b0;
    end else begin
      out_reg   <= out_next;
      dir_reg   <= dir_next;
      ien_reg   <= ien_next;
      iedge_reg <= iedge_next;
      pend_reg  <= pend_next;
      rdata_reg <= rdata_next;
      irq_reg   <= irq_next;
    end
  end

  assign rdata    = rdata_reg;
  assign gpio_out = out_reg;
  assign gpio_oe  = dir_reg;
  assign irq      = irq_reg;

endmodule

// File: tb/tb_gpio_ctrl.sv
module tb_gpio_ctrl;
  import gpio_pkg::*;

  localparam int DW          = 16;
  localparam int SYNC_STAGES = 2;
  localparam int DB_CYCLES   = 4;
`ifdef GPIO_DEBOUNCE_EN
  localparam int LAT = SYNC_STAGES + DB_CYCLES;
`else
  localparam int LAT = SYNC_STAGES;
`endif

  logic          clk;
  logic          rst;
  logic          sel;
  logic          we;
  logic [2:0]    addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic [DW-1:0] gpio_in;
  logic [DW-1:0] gpio_out;
  logic [DW-1:0] gpio_oe;
  logic          irq;

  int tests_run;
  int tests_failed;

  gpio_ctrl #(
    .DW          (DW),
    .SYNC_STAGES (SYNC_STAGES),
    .DB_CYCLES   (DB_CYCLES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sel      (sel),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .gpio_oe  (gpio_oe),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive at the falling edge; the access is taken on the next rising edge.
  task automatic bus_write(input logic [2:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    sel = 1'b0; we = 1'b0;
    $display("[TB] WR addr=%0d data=%h", a, d);
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [DW-1:0] d);
    @(negedge clk);
    sel = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    sel = 1'b0;
    d = rdata;
    $display("[TB] RD addr=%0d data=%h", a, d);
  endtask

  task automatic settle();
    repeat (LAT + 3) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [DW-1:0] v;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (gpio_out !== 16'h0000) begin
      tests_failed++; $display("FAIL reset_gpio_out: got %h expected 0000", gpio_out);
    end
    tests_run++;
    if (gpio_oe !== 16'h0000) begin
      tests_failed++; $display("FAIL reset_gpio_oe: got %h expected 0000", gpio_oe);
    end
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++; $display("FAIL reset_irq: got %b expected 0", irq);
    end
    tests_run++;
    if (rdata !== 16'h0000) begin
      tests_failed++; $display("FAIL reset_rdata: got %h expected 0000", rdata);
    end
    for (int i = 0; i < 8; i++) begin
      bus_read(3'(i), v);
      tests_run++;
      if (v !== 16'h0000) begin
        tests_failed++; $display("FAIL reset_reg[%0d]: got %h expected 0000", i, v);
      end
    end
  endtask

  task automatic test_out_setclr();
    logic [DW-1:0] v;
    bus_write(REG_DIR, 16'hFFFF);
    tests_run++;
    if (gpio_oe !== 16'hFFFF) begin
      tests_failed++; $display("FAIL dir_oe: got %h expected FFFF", gpio_oe);
    end
    bus_write(REG_OUT, 16'h00F0);
    bus_write(REG_SET, 16'h0F00);
    bus_write(REG_CLR, 16'h0030);
    tests_run++;
    if (gpio_out !== 16'h0FC0) begin
      tests_failed++; $display("FAIL setclr_out: got %h expected 0FC0", gpio_out);
    end
    bus_read(REG_OUT, v);
    tests_run++;
    if (v !== 16'h0FC0) begin
      tests_failed++; $display("FAIL read_out: got %h expected 0FC0", v);
    end
    bus_read(REG_SET, v);
    tests_run++;
    if (v !== 16'h0000) begin
      tests_failed++; $display("FAIL read_set: got %h expected 0000", v);
    end
    bus_read(REG_CLR, v);
    tests_run++;
    if (v !== 16'h0000) begin
      tests_failed++; $display("FAIL read_clr: got %h expected 0000", v);
    end
  endtask

  // Continuous reads of IN: at negedge i, rdata holds the value sampled at
  // rising edge i, i.e. the IN value after edge i-1.
  task automatic test_in_sync();
    bus_write(REG_DIR, 16'h0000);
    @(negedge clk);
    gpio_in = 16'hFA1C;
    sel = 1'b1; we = 1'b0; addr = REG_IN;
    for (int i = 1; i <= LAT + 1; i++) begin
      @(negedge clk);
      if (i == LAT) begin
        tests_run++;
        if (rdata !== 16'h0000) begin
          tests_failed++; $display("FAIL in_early: got %h expected 0000", rdata);
        end
      end
      if (i == LAT + 1) begin
        tests_run++;
        if (rdata !== 16'hFA1C) begin
          tests_failed++; $display("FAIL in_value: got %h expected FA1C", rdata);
        end
      end
    end
    sel = 1'b0;
    $display("[TB] IN latency window checked, LAT=%0d", LAT);
  endtask

  task automatic test_irq();
    logic [DW-1:0] v;
    gpio_in = 16'hFA1E;
    settle();
    bus_write(REG_PEND, 16'hFFFF);
    bus_write(REG_IEDGE, 16'h0001);
    bus_write(REG_IEN, 16'h0003);
    bus_write(REG_PEND, 16'hFFFF);
    bus_read(REG_PEND, v);
    tests_run++;
    if (v !== 16'h0000) begin
      tests_failed++; $display("FAIL irq_pend_clean: got %h expected 0000", v);
    end
    @(negedge clk);
    gpio_in = 16'hFA1D;  // bit0 rises, bit1 falls
    settle();
    bus_read(REG_PEND, v);
    tests_run++;
    if (v !== 16'h0003) begin
      tests_failed++; $display("FAIL irq_pend_both: got %h expected 0003", v);
    end
    tests_run++;
    if (irq !== 1'b1) begin
      tests_failed++; $display("FAIL irq_set: got %b expected 1", irq);
    end
    bus_write(REG_PEND, 16'h0001);
    bus_read(REG_PEND, v);
    tests_run++;
    if (v !== 16'h0002) begin
      tests_failed++; $display("FAIL irq_w1c_bit0: got %h expected 0002", v);
    end
    tests_run++;
    if (irq !== 1'b1) begin
      tests_failed++; $display("FAIL irq_hold: got %b expected 1", irq);
    end
    bus_write(REG_PEND, 16'h0002);
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++; $display("FAIL irq_clear: got %b expected 0", irq);
    end
  endtask

  task automatic test_dir_mask();
    logic [DW-1:0] v;
    bus_write(REG_DIR, 16'h0001);
    tests_run++;
    if (gpio_oe !== 16'h0001) begin
      tests_failed++; $display("FAIL mask_oe: got %h expected 0001", gpio_oe);
    end
    gpio_in = 16'hFA1C;
    settle();
    gpio_in = 16'hFA1D;
    settle();
    bus_read(REG_PEND, v);
    tests_run++;
    if (v !== 16'h0000) begin
      tests_failed++; $display("FAIL mask_pend: got %h expected 0000", v);
    end
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++; $display("FAIL mask_irq: got %b expected 0", irq);
    end
  endtask

  // Rising edge on bit2 lands in PEND on the same edge as a W1C of bit2.
  task automatic test_back_to_back();
    logic [DW-1:0] v;
    bus_write(REG_DIR, 16'h0000);
    bus_write(REG_IEDGE, 16'h0004);
    bus_write(REG_IEN, 16'h0004);
    gpio_in = 16'hFA19;
    settle();
    bus_write(REG_PEND, 16'hFFFF);
    bus_read(REG_PEND, v);
    tests_run++;
    if (v !== 16'h0000) begin
      tests_failed++; $display("FAIL b2b_pend_clean: got %h expected 0000", v);
    end
    @(negedge clk);
    gpio_in = 16'hFA1D;
    repeat (LAT) @(negedge clk);
    sel = 1'b1; we = 1'b1; addr = REG_PEND; wdata = 16'h0004;
    @(negedge clk);
    sel = 1'b0; we = 1'b0;
    $display("[TB] WR addr=%0d data=%h (same cycle as edge)", REG_PEND, 16'h0004);
    tests_run++;
    if (irq !== 1'b1) begin
      tests_failed++; $display("FAIL b2b_irq: got %b expected 1", irq);
    end
    bus_read(REG_PEND, v);
    tests_run++;
    if (v !== 16'h0004) begin
      tests_failed++; $display("FAIL b2b_pend: got %h expected 0004", v);
    end
    bus_write(REG_PEND, 16'h0004);
    bus_read(REG_PEND, v);
    tests_run++;
    if (v !== 16'h0000) begin
      tests_failed++; $display("FAIL b2b_w1c: got %h expected 0000", v);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] v;
    gpio_in = 16'hFA19;
    settle();
    gpio_in = 16'hFA1D;
    settle();
    tests_run++;
    if (irq !== 1'b1) begin
      tests_failed++; $display("FAIL rstmid_pre_irq: got %b expected 1", irq);
    end
    bus_write(REG_OUT, 16'hFFFF);
    bus_write(REG_DIR, 16'hFFFF);
    bus_read(REG_DIR, v);
    tests_run++;
    if (v !== 16'hFFFF) begin
      tests_failed++; $display("FAIL rstmid_pre_dir: got %h expected FFFF", v);
    end
    @(negedge clk);
    sel = 1'b1; we = 1'b1; addr = REG_OUT; wdata = 16'h1234; rst = 1'b1;
    @(negedge clk);
    $display("[TB] WR addr=%0d data=%h aborted by reset", REG_OUT, 16'h1234);
    tests_run++;
    if (gpio_out !== 16'h0000) begin
      tests_failed++; $display("FAIL rstmid_out: got %h expected 0000", gpio_out);
    end
    tests_run++;
    if (gpio_oe !== 16'h0000) begin
      tests_failed++; $display("FAIL rstmid_oe: got %h expected 0000", gpio_oe);
    end
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++; $display("FAIL rstmid_irq: got %b expected 0", irq);
    end
    tests_run++;
    if (rdata !== 16'h0000) begin
      tests_failed++; $display("FAIL rstmid_rdata: got %h expected 0000", rdata);
    end
    sel = 1'b0; we = 1'b0; rst = 1'b0;
    bus_read(REG_OUT, v);
    tests_run++;
    if (v !== 16'h0000) begin
      tests_failed++; $display("FAIL rstmid_out_reg: got %h expected 0000", v);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst     = 1'b1;
    sel     = 1'b0;
    we      = 1'b0;
    addr    = 3'd0;
    wdata   = '0;
    gpio_in = '0;

    test_reset();
    test_out_setclr();
    test_in_sync();
    test_irq();
    test_dir_mask();
    test_back_to_back();
    test_reset_mid();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
